// File: rtl/mgmt_pkg.sv
// Shared register offsets, ID constants and address decode for mgmt_ctl.
package mgmt_pkg;

  localparam logic [31:0] OFF_IOM    = 32'h00;
  localparam logic [31:0] OFF_LOOP   = 32'h04;
  localparam logic [31:0] OFF_RST    = 32'h08;
  localparam logic [31:0] OFF_EVT    = 32'h0C;
  localparam logic [31:0] OFF_IRQ_EN = 32'h10;
  localparam logic [31:0] OFF_ID     = 32'h14;

  localparam logic [7:0] ID_VERSION = 8'h02;

  typedef enum logic [2:0] {
    REG_IOM,
    REG_LOOP,
    REG_RST,
    REG_EVT,
    REG_IRQ_EN,
    REG_ID,
    REG_BAD
  } reg_sel_e;

  // Offset arrives zero-extended; anything unaligned or past ID is REG_BAD.
  function automatic reg_sel_e decode_reg(input logic [31:0] off);
    reg_sel_e sel;
    case (off)
      OFF_IOM:    sel = REG_IOM;
      OFF_LOOP:   sel = REG_LOOP;
      OFF_RST:    sel = REG_RST;
      OFF_EVT:    sel = REG_EVT;
      OFF_IRQ_EN: sel = REG_IRQ_EN;
      OFF_ID:     sel = REG_ID;
      default:    sel = REG_BAD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sys_bus_if.sv
// 32-bit single-cycle-ack register bus between a master and mapped blocks.
interface sys_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport m (output addr, wdata, wen, ren, input rdata, ack, err);
  modport s (input addr, wdata, wen, ren, output rdata, ack, err);
endinterface

// File: rtl/mgmt_rst_gen.sv
// Per-channel soft-reset pulse generator: reloadable down-counter,
// output held low while the count is non-zero.
module mgmt_rst_gen #(
  parameter int RSTL = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic busy,
  output logic rstn_out
);

  localparam int CW = $clog2(RSTL + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  // Next count: restart on start (extends a running pulse), else count down to zero.
  always_comb begin
    cnt_d = cnt;
    if (start) begin
      cnt_d = CW'(RSTL);
    end else if (cnt != '0) begin
      cnt_d = cnt - CW'(1);
    end
  end

  // Counter reloads on reset so release produces a power-on pulse.
  // rstn_out registers the next-state idle flag so it tracks ~busy exactly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= CW'(RSTL);
      rstn_out <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      rstn_out <= (cnt_d == '0);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/mgmt_ctl.sv
// Second-generation management block: GPIO mode, loop selects, soft resets,
// sticky W1C events with masked interrupt, ID register, bus error on unmapped.
module mgmt_ctl
  import mgmt_pkg::*;
#(
  parameter int GW   = 8,
  parameter int CN   = 2,
  parameter int LW   = 2,
  parameter int RSTL = 16,
  parameter int BAW  = 5
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [GW-1:0]   cfg_iom,
  output logic [CN*LW-1:0] cfg_loop,
  output logic [CN-1:0]   ctl_rstn,
  input  logic [CN-1:0]   sts_evt,
  output logic            irq,
  sys_bus_if.s            bus
);

  localparam logic [31:0] ID_VALUE = {ID_VERSION, 8'(CN), 8'(LW), 8'(GW)};

  logic [CN-1:0]    evt;
  logic [CN-1:0]    irq_en;
  logic [CN-1:0]    busy;

  logic [GW-1:0]    iom_d;
  logic [CN*LW-1:0] loop_d;
  logic [CN-1:0]    evt_d;
  logic [CN-1:0]    irq_en_d;
  logic [CN-1:0]    rst_start;
  logic [CN-1:0]    evt_clr;
  logic [31:0]      rd_val;
  logic [31:0]      rdata_d;

  reg_sel_e sel;
  logic     access;
  logic     bad;
  logic     wr_ok;

  assign sel    = decode_reg(32'(bus.addr[BAW-1:0]));
  assign access = bus.wen | bus.ren;
  assign bad    = (sel == REG_BAD);
  assign wr_ok  = bus.wen & ~bad;

  // Register next-state: writes land on the same edge the access is sampled.
  always_comb begin
    iom_d     = cfg_iom;
    loop_d    = cfg_loop;
    irq_en_d  = irq_en;
    rst_start = '0;
    evt_clr   = '0;
    if (wr_ok) begin
      case (sel)
        REG_IOM:    iom_d     = bus.wdata[GW-1:0];
        REG_LOOP:   loop_d    = bus.wdata[CN*LW-1:0];
        REG_RST:    rst_start = bus.wdata[CN-1:0];
        REG_EVT:    evt_clr   = bus.wdata[CN-1:0];
        REG_IRQ_EN: irq_en_d  = bus.wdata[CN-1:0];
        default:    ;
      endcase
    end
    // new event takes priority over a concurrent clear
    evt_d = (evt & ~evt_clr) | sts_evt;
  end

  // Read mux from current (pre-write) state; unmapped and write-only return zero.
  always_comb begin
    rd_val = '0;
    case (sel)
      REG_IOM:    rd_val[GW-1:0]    = cfg_iom;
      REG_LOOP:   rd_val[CN*LW-1:0] = cfg_loop;
      REG_RST:    rd_val[CN-1:0]    = busy;
      REG_EVT:    rd_val[CN-1:0]    = evt;
      REG_IRQ_EN: rd_val[CN-1:0]    = irq_en;
      REG_ID:     rd_val            = ID_VALUE;
      default:    rd_val            = '0;
    endcase
    rdata_d = (bus.ren && !bad) ? rd_val : '0;
  end

  // Config/event state and the one-cycle bus response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_iom   <= '0;
      cfg_loop  <= '0;
      evt       <= '0;
      irq_en    <= '0;
      irq       <= 1'b0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      cfg_iom   <= iom_d;
      cfg_loop  <= loop_d;
      evt       <= evt_d;
      irq_en    <= irq_en_d;
      irq       <= |(evt & irq_en);
      bus.ack   <= access;
      bus.err   <= access & bad;
      bus.rdata <= rdata_d;
    end
  end

  for (genvar n = 0; n < CN; n++) begin : g_rst
    mgmt_rst_gen #(.RSTL(RSTL)) u_rst_gen (
      .clk      (clk),
      .rstn     (rstn),
      .start    (rst_start[n]),
      .busy     (busy[n]),
      .rstn_out (ctl_rstn[n])
    );
  end

endmodule

// File: tb/tb_mgmt_ctl.sv
// Scoreboard bench for mgmt_ctl: stimulus pushes expected bus responses,
// a negedge monitor pops on every ack; side outputs checked directly.
module tb_mgmt_ctl;

  localparam logic [31:0] ID_EXP = 32'h0202_0208;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] cfg_iom;
  logic [3:0] cfg_loop;
  logic [1:0] ctl_rstn;
  logic [1:0] sts_evt;
  logic       irq;

  sys_bus_if bus ();

  mgmt_ctl #(
    .GW   (8),
    .CN   (2),
    .LW   (2),
    .RSTL (16),
    .BAW  (5)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cfg_iom  (cfg_iom),
    .cfg_loop (cfg_loop),
    .ctl_rstn (ctl_rstn),
    .sts_evt  (sts_evt),
    .irq      (irq),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_ack: got ack with empty scoreboard (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("err@%h", e.addr), 32'(bus.err), 32'(e.err));
        if (e.chk_rd) check($sformatf("rdata@%h", e.addr), bus.rdata, e.rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr);
    exp_t e;
    bus.wen   = w;
    bus.ren   = r;
    bus.addr  = a;
    bus.wdata = d;
    e.addr    = a;
    e.rd      = erd;
    e.err     = eerr;
    e.chk_rd  = r;
    q.push_back(e);
  endtask

  task automatic bus_op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eerr);
    issue(w, r, a, d, erd, eerr);
    tick();
    idle();
  endtask

  task automatic power_on(input string tag);
    rstn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check({tag, "_ctl_rstn"}, 32'(ctl_rstn), (i >= 16) ? 32'd3 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn    = 1'b0;
    sts_evt = '0;
    idle();
    repeat (3) tick();

    check("rst_iom",   32'(cfg_iom),   32'd0);
    check("rst_loop",  32'(cfg_loop),  32'd0);
    check("rst_ctl",   32'(ctl_rstn),  32'd0);
    check("rst_irq",   32'(irq),       32'd0);
    check("rst_ack",   32'(bus.ack),   32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    check("rst_rdata", bus.rdata,      32'd0);

    power_on("por");

    // ID read, ack exactly one cycle
    issue(1'b0, 1'b1, 32'h14, '0, ID_EXP, 1'b0);
    tick();
    idle();
    check("ack_latency", 32'(bus.ack), 32'd1);
    tick();
    check("ack_single", 32'(bus.ack), 32'd0);

    // IOM write then back-to-back read
    bus_op(1'b1, 1'b0, 32'h00, 32'hA5, '0, 1'b0);
    check("iom_out", 32'(cfg_iom), 32'hA5);
    bus_op(1'b0, 1'b1, 32'h00, '0, 32'hA5, 1'b0);
    bus_op(1'b1, 1'b0, 32'h04, 32'hFF, '0, 1'b0);
    check("loop_out", 32'(cfg_loop), 32'hF);
    bus_op(1'b0, 1'b1, 32'h04, '0, 32'hF, 1'b0);
    // write+read together returns pre-write value
    bus_op(1'b1, 1'b1, 32'h00, 32'h3C, 32'hA5, 1'b0);
    check("iom_rw", 32'(cfg_iom), 32'h3C);

    // soft reset channel 1, extended by a second write
    bus_op(1'b1, 1'b0, 32'h08, 32'h2, '0, 1'b0);
    check("rst1_k0", 32'(ctl_rstn), 32'd1);
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) issue(1'b0, 1'b1, 32'h08, '0, 32'h2, 1'b0);
      if (k == 5) issue(1'b1, 1'b0, 32'h08, 32'h2, '0, 1'b0);
      tick();
      idle();
      check($sformatf("rst1_k%0d", k), 32'(ctl_rstn), (k >= 21) ? 32'd3 : 32'd1);
    end

    // events and interrupt
    bus_op(1'b1, 1'b0, 32'h10, 32'h1, '0, 1'b0);
    sts_evt = 2'b01;
    tick();
    sts_evt = '0;
    check("irq_d1", 32'(irq), 32'd0);
    tick();
    check("irq_d2", 32'(irq), 32'd1);
    bus_op(1'b0, 1'b1, 32'h0C, '0, 32'h1, 1'b0);
    sts_evt = 2'b01;
    issue(1'b1, 1'b0, 32'h0C, 32'h1, '0, 1'b0);
    tick();
    sts_evt = '0;
    idle();
    bus_op(1'b0, 1'b1, 32'h0C, '0, 32'h1, 1'b0);
    bus_op(1'b1, 1'b0, 32'h0C, 32'h1, '0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h0C, '0, 32'h0, 1'b0);
    check("irq_cleared", 32'(irq), 32'd0);
    sts_evt = 2'b10;
    tick();
    sts_evt = '0;
    tick();
    check("irq_masked", 32'(irq), 32'd0);
    bus_op(1'b0, 1'b1, 32'h0C, '0, 32'h2, 1'b0);
    bus_op(1'b1, 1'b0, 32'h0C, 32'h3, '0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h0C, '0, 32'h0, 1'b0);

    // unmapped and read-only accesses
    bus_op(1'b0, 1'b1, 32'h18, '0, 32'h0, 1'b1);
    bus_op(1'b1, 1'b0, 32'h02, 32'hFF, '0, 1'b1);
    check("bad_wr_iom", 32'(cfg_iom), 32'h3C);
    bus_op(1'b0, 1'b1, 32'h05, '0, 32'h0, 1'b1);
    bus_op(1'b0, 1'b1, 32'h00, '0, 32'h3C, 1'b0);
    bus_op(1'b1, 1'b0, 32'h14, 32'h0, '0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h14, '0, ID_EXP, 1'b0);

    // reset mid-pulse with pending ack
    sts_evt = 2'b01;
    tick();
    sts_evt = '0;
    tick();
    check("pre_rst_irq", 32'(irq), 32'd1);
    bus_op(1'b1, 1'b0, 32'h08, 32'h1, '0, 1'b0);
    check("pre_rst_ctl", 32'(ctl_rstn), 32'd2);
    repeat (3) tick();
    issue(1'b0, 1'b1, 32'h00, '0, 32'h3C, 1'b0);
    @(posedge clk);
    #1;
    idle();
    check("pend_ack", 32'(bus.ack), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("arst_ack",   32'(bus.ack),  32'd0);
    check("arst_err",   32'(bus.err),  32'd0);
    check("arst_rdata", bus.rdata,     32'd0);
    check("arst_iom",   32'(cfg_iom),  32'd0);
    check("arst_loop",  32'(cfg_loop), 32'd0);
    check("arst_ctl",   32'(ctl_rstn), 32'd0);
    check("arst_irq",   32'(irq),      32'd0);
    check("arst_sb",    32'(q.size()), 32'd1);
    q.delete();
    repeat (2) tick();
    power_on("por2");
    bus_op(1'b0, 1'b1, 32'h00, '0, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h0C, '0, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h10, '0, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h08, '0, 32'h0, 1'b0);

    repeat (2) tick();
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
